// File: rtl/light_delay_seq.sv
// rtl/light_delay_seq.sv - start-light sequencer: fill lights per tick, random hold, then done pulse
// Optional abort input is compiled in with `define SEQ_ABORT_EN.
`timescale 1ns/1ps

module light_delay_seq #(
   parameter int N_LIGHTS  = 8,
   parameter int LFSR_W    = 7,
   parameter int MIN_DELAY = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                trigger,
   input  logic                tick,
`ifdef SEQ_ABORT_EN
   input  logic                abort,
`endif
   input  logic [LFSR_W-1:0]   lfsr_data,
   output logic                lfsr_en,
   output logic [N_LIGHTS-1:0] lights,
   output logic                busy,
   output logic                done
);

   localparam int CNT_W = LFSR_W + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      FILL   = 2'b01,
      HOLD   = 2'b10,
      UNUSED = 2'b11
   } state_t;

   state_t              r_state,  w_state_nxt;
   logic [N_LIGHTS-1:0] r_lights, w_lights_nxt;
   logic [CNT_W-1:0]    r_count,  w_count_nxt;
   logic                r_busy,   w_busy_nxt;
   logic                r_done,   w_done_nxt;
   logic                w_abort;
   logic [CNT_W-1:0]    w_capture;

`ifdef SEQ_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   // Extra bit keeps lfsr_data + MIN_DELAY from wrapping at the all-ones LFSR value.
   assign w_capture = {1'b0, lfsr_data} + CNT_W'(MIN_DELAY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_lights <= '0;
         r_count  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_lights <= w_lights_nxt;
         r_count  <= w_count_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_lights_nxt = r_lights;
      w_count_nxt  = r_count;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      case (r_state)
         IDLE: begin
            if (trigger) begin
               w_state_nxt  = FILL;
               w_lights_nxt = '0;
               w_count_nxt  = '0;
               w_busy_nxt   = 1'b1;
            end
         end
         FILL: begin
            if (w_abort) begin
               w_state_nxt  = IDLE;
               w_lights_nxt = '0;
               w_busy_nxt   = 1'b0;
            end else if (tick) begin
               w_lights_nxt = {r_lights[N_LIGHTS-2:0], 1'b1};
               if (&r_lights[N_LIGHTS-2:0]) begin
                  w_count_nxt = w_capture;
                  w_state_nxt = HOLD;
               end
            end
         end
         HOLD: begin
            if (w_abort) begin
               w_state_nxt  = IDLE;
               w_lights_nxt = '0;
               w_count_nxt  = '0;
               w_busy_nxt   = 1'b0;
            end else if (tick) begin
               if (r_count == CNT_W'(1)) begin
                  w_state_nxt  = IDLE;
                  w_lights_nxt = '0;
                  w_count_nxt  = '0;
                  w_busy_nxt   = 1'b0;
                  w_done_nxt   = 1'b1;
               end else begin
                  w_count_nxt = r_count - CNT_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt  = IDLE;
            w_lights_nxt = '0;
            w_count_nxt  = '0;
            w_busy_nxt   = 1'b0;
         end
      endcase
   end

   assign lfsr_en = (r_state == IDLE);
   assign lights  = r_lights;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: tb/tb_light_delay_seq.sv
// tb/tb_light_delay_seq.sv - directed checks for light_delay_seq with a bench LFSR and forced capture value
`timescale 1ns/1ps

module tb_light_delay_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       trigger = 1'b0;
   logic       tick = 1'b0;
`ifdef SEQ_ABORT_EN
   logic       abort = 1'b0;
`endif
   logic [6:0] lfsr_data;
   logic       lfsr_en;
   logic [7:0] lights;
   logic       busy;
   logic       done;

   logic [6:0] lfsr_q;
   logic       f_en = 1'b0;
   logic [6:0] f_val = 7'h01;
   int         n_tests = 0;
   int         n_fail = 0;
   int         done_cnt = 0;

   always #5 clk = ~clk;

   light_delay_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .trigger   (trigger),
      .tick      (tick),
`ifdef SEQ_ABORT_EN
      .abort     (abort),
`endif
      .lfsr_data (lfsr_data),
      .lfsr_en   (lfsr_en),
      .lights    (lights),
      .busy      (busy),
      .done      (done)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)       lfsr_q <= 7'h01;
      else if (lfsr_en) lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
   end
   assign lfsr_data = f_en ? f_val : lfsr_q;

   always @(posedge clk) if (rst_n && done) done_cnt <= done_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Triggers a sequence and ticks every (gap+1) cycles until done; returns ticks used.
   task automatic run_seq(input logic [6:0] val, input int gap, input logic noise, output int nt);
      logic seen;
      f_val = val;
      f_en = 1'b1;
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      nt = 0;
      seen = 1'b0;
      while (!seen && nt < 300) begin
         tick = 1'b1;
         trigger = noise;
         step();
         tick = 1'b0;
         trigger = 1'b0;
         nt++;
         if (done) seen = 1'b1;
         else repeat (gap) step();
      end
      check("seq_done_seen", 32'(seen), 32'd1);
   endtask

   initial begin
      int nt;
      int dc0;
      logic [6:0] lq_snap;

      repeat (3) step();
      check("rst_lights", 32'(lights), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_lfsr_en", 32'(lfsr_en), 32'h1);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_lights", 32'(lights), 32'h0);
         check("idle_busy", 32'(busy), 32'h0);
         check("idle_done", 32'(done), 32'h0);
         check("idle_lfsr_en", 32'(lfsr_en), 32'h1);
      end

      // Sequence with lfsr_data=5: fill 8 ticks, hold 6 ticks
      f_val = 7'h05;
      f_en = 1'b1;
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      lq_snap = lfsr_q;
      check("trig_busy", 32'(busy), 32'h1);
      check("trig_lights", 32'(lights), 32'h0);
      check("trig_lfsr_en", 32'(lfsr_en), 32'h0);
      for (int i = 1; i <= 8; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         check("fill_lights", 32'(lights), (32'd1 << i) - 32'd1);
         step();
      end
      for (int i = 1; i <= 5; i++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         check("hold_done_low", 32'(done), 32'h0);
         check("hold_lights", 32'(lights), 32'hFF);
         check("hold_busy", 32'(busy), 32'h1);
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("end_done", 32'(done), 32'h1);
      check("end_lights", 32'(lights), 32'h0);
      check("end_busy", 32'(busy), 32'h0);
      check("lfsr_frozen", 32'(lfsr_q), 32'(lq_snap));
      step();
      check("done_one_cycle", 32'(done), 32'h0);
      check("idle_lfsr_en_again", 32'(lfsr_en), 32'h1);

      // Maximum LFSR value: 8 + 127 + 1 ticks, back-to-back
      run_seq(7'h7F, 0, 1'b0, nt);
      check("max_ticks", 32'(nt), 32'd136);
      step();

      // Minimum hold of 2 ticks, spaced ticks
      run_seq(7'h01, 2, 1'b0, nt);
      check("min_ticks", 32'(nt), 32'd10);
      step();

      // Trigger asserted throughout FILL and HOLD must not restart or queue
      dc0 = done_cnt;
      run_seq(7'h03, 1, 1'b1, nt);
      check("noise_ticks", 32'(nt), 32'd12);
      repeat (4) step();
      check("noise_one_done", 32'(done_cnt - dc0), 32'd1);
      check("noise_idle_busy", 32'(busy), 32'h0);

      // Trigger coincident with tick in IDLE: that tick is ignored
      f_val = 7'h7F;
      trigger = 1'b1;
      tick = 1'b1;
      step();
      trigger = 1'b0;
      tick = 1'b0;
      check("coinc_lights", 32'(lights), 32'h0);
      check("coinc_busy", 32'(busy), 32'h1);
      tick = 1'b1;
      step();
      check("coinc_next", 32'(lights), 32'h01);
      repeat (9) step();
      tick = 1'b0;
      check("pre_rst_lights", 32'(lights), 32'hFF);

      // Asynchronous reset in HOLD
      dc0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check("async_lights", 32'(lights), 32'h0);
      check("async_busy", 32'(busy), 32'h0);
      check("async_lfsr_en", 32'(lfsr_en), 32'h1);
      step();
      rst_n = 1'b1;
      repeat (3) step();
      check("async_no_done", 32'(done_cnt - dc0), 32'd0);

`ifdef SEQ_ABORT_EN
      dc0 = done_cnt;
      f_val = 7'h05;
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      repeat (3) begin
         tick = 1'b1;
         step();
      end
      tick = 1'b0;
      check("abort_pre", 32'(lights), 32'h07);
      abort = 1'b1;
      tick = 1'b1;
      step();
      abort = 1'b0;
      tick = 1'b0;
      check("abort_lights", 32'(lights), 32'h0);
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_lfsr_en", 32'(lfsr_en), 32'h1);
      repeat (3) step();
      check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
